hit_judge: RTL and testbench

Round controller and scorer that drives the target generator from the consuming end of its handshake. It compares the player cursor against the current target, decides hit or miss on a fire press or a timeout, and pulses `result_valid` so the generator advances to the next target. It also keeps score and miss counts and owns the round state machine of the game core.

---
 rtl/hit_judge_pkg.sv | 16 +
 rtl/dffre.sv | 20 ++
 rtl/judge_timer.sv | 36 +++
 rtl/hit_judge.sv | 147 ++++++++++++++
 tb/tb_hit_judge.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/hit_judge_pkg.sv
// Shared types and constants for the hit_judge round controller.
package hit_judge_pkg;

   localparam int unsigned COORD_W = 5;
   localparam int unsigned MISS_W  = 4;
   localparam int unsigned STATE_W = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_SETTLE = 3'd1;
   localparam state_t ST_TRACK  = 3'd2;
   localparam state_t ST_RESULT = 3'd3;
   localparam state_t ST_OVER   = 3'd4;

endpackage

// File: rtl/dffre.sv
// Enabled flop with synchronous active-high reset to zero.
module dffre #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         r,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (r) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/judge_timer.sv
// TRACK-state cycle timer; expired flags the last allowed TRACK cycle.
module judge_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   dffre #(.W(CNT_W)) u_count (
      .clk (clk),
      .r   (reset),
      .en  (clear | enable),
      .d   (count_d),
      .q   (count_q)
   );

   assign expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hit_judge.sv
// Round controller and scorer for the target game core.
// Optional HIT_JUDGE_TOLERANCE_EN relaxes the X match to a distance of 1.
module hit_judge
   import hit_judge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned SCORE_W        = 8,
   parameter int unsigned MAX_MISSES     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               fire,
   input  logic [COORD_W-1:0] player_x,
   input  logic [COORD_W-1:0] player_y,
   input  logic [COORD_W-1:0] target_x,
   input  logic [COORD_W-1:0] target_y,
   output logic               result_valid,
   output logic               hit,
   output logic [SCORE_W-1:0] score,
   output logic [MISS_W-1:0]  misses,
   output logic               game_over
);

   state_t state_d, state_q;
   logic fire_q, rv_d, rv_q, go_d, go_q;
   logic hit_en, hit_d, hit_q;
   logic score_en, misses_en;
   logic [SCORE_W-1:0] score_d, score_q;
   logic [MISS_W-1:0]  misses_d, misses_q, misses_inc;
   logic timer_clr, timer_en, expired;
   logic fire_edge, x_ok, y_ok, match;

`ifdef HIT_JUDGE_TOLERANCE_EN
   // Widened by one bit so the +/-1 neighbours never wrap around the grid edge.
   localparam int unsigned XD_W = COORD_W + 1;
   logic [XD_W-1:0] px_w, tx_w;
   assign px_w = {1'b0, player_x};
   assign tx_w = {1'b0, target_x};
   assign x_ok = (px_w == tx_w) || (px_w == tx_w + XD_W'(1)) || (tx_w == px_w + XD_W'(1));
`else
   assign x_ok = (player_x == target_x);
`endif
   assign y_ok  = (player_y == target_y);
   assign match = x_ok & y_ok;

   assign fire_edge  = fire & ~fire_q;
   assign misses_inc = (misses_q >= MISS_W'(MAX_MISSES)) ? misses_q : misses_q + MISS_W'(1);

   always_comb begin
      state_d   = state_q;
      hit_en    = 1'b0;
      hit_d     = match;
      score_en  = 1'b0;
      score_d   = score_q + SCORE_W'(1);
      misses_en = 1'b0;
      misses_d  = misses_inc;
      timer_clr = 1'b0;
      timer_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            timer_clr = 1'b1;
            state_d   = ST_TRACK;
         end
         ST_TRACK: begin
            timer_en = 1'b1;
            if (fire_edge) begin
               hit_en  = 1'b1;
               state_d = ST_RESULT;
            end else if (expired) begin
               hit_en  = 1'b1;
               hit_d   = 1'b0;
               state_d = ST_RESULT;
            end
         end
         ST_RESULT: begin
            if (hit_q) begin
               score_en = (score_q != '1);
            end else begin
               misses_en = 1'b1;
            end
            // Game ends when the post-update miss count reaches the limit.
            if (!hit_q && (misses_inc == MISS_W'(MAX_MISSES))) begin
               state_d = ST_OVER;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_OVER: begin
            if (start) begin
               score_en  = 1'b1;
               score_d   = '0;
               misses_en = 1'b1;
               misses_d  = '0;
               state_d   = ST_SETTLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rv_d = (state_d == ST_RESULT);
      go_d = (state_d == ST_OVER);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         fire_q  <= 1'b0;
         rv_q    <= 1'b0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         fire_q  <= fire;
         rv_q    <= rv_d;
         go_q    <= go_d;
      end
   end

   dffre #(.W(1)) u_hit (
      .clk (clk), .r (reset), .en (hit_en), .d (hit_d), .q (hit_q)
   );

   dffre #(.W(SCORE_W)) u_score (
      .clk (clk), .r (reset), .en (score_en), .d (score_d), .q (score_q)
   );

   dffre #(.W(MISS_W)) u_misses (
      .clk (clk), .r (reset), .en (misses_en), .d (misses_d), .q (misses_q)
   );

   judge_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clr),
      .enable  (timer_en),
      .expired (expired)
   );

   assign result_valid = rv_q;
   assign hit          = hit_q;
   assign score        = score_q;
   assign misses       = misses_q;
   assign game_over    = go_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: TIMEOUT_CYCLES=16, SCORE_W=2, MAX_MISSES=2.
module tb_hit_judge;

   logic       clk;
   logic       reset;
   logic       start;
   logic       fire;
   logic [4:0] player_x, player_y, target_x, target_y;
   logic       result_valid, hit, game_over;
   logic [1:0] score;
   logic [3:0] misses;

   int checks   = 0;
   int failures = 0;
   int rv_cnt   = 0;
   int b2b      = 0;
   logic rv_prev = 1'b0;
   int base;

   hit_judge #(.TIMEOUT_CYCLES(16), .SCORE_W(2), .MAX_MISSES(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .fire         (fire),
      .player_x     (player_x),
      .player_y     (player_y),
      .target_x     (target_x),
      .target_y     (target_y),
      .result_valid (result_valid),
      .hit          (hit),
      .score        (score),
      .misses       (misses),
      .game_over    (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count result_valid pulses and flag any two in a row.
   always @(posedge clk) begin
      if (result_valid === 1'b1) begin
         rv_cnt <= rv_cnt + 1;
         if (rv_prev) b2b <= b2b + 1;
      end
      rv_prev <= (result_valid === 1'b1);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called on a TRACK negedge with fire low; returns on the next TRACK entry negedge.
   task automatic judge(input string tag, input logic exp_hit, input int exp_score, input int exp_miss);
      fire = 1'b1;
      tick();
      chk({tag, "_rv"}, 32'(result_valid), 32'd1);
      chk({tag, "_hit"}, 32'(hit), 32'(exp_hit));
      fire = 1'b0;
      tick();
      chk({tag, "_rv_low"}, 32'(result_valid), 32'd0);
      chk({tag, "_score"}, 32'(score), 32'(exp_score));
      chk({tag, "_misses"}, 32'(misses), 32'(exp_miss));
      tick();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; fire = 1'b0;
      player_x = 5'd0; player_y = 5'd0; target_x = 5'd0; target_y = 5'd0;
      tick(3);
      reset = 1'b0;
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_hit", 32'(hit), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      chk("rst_misses", 32'(misses), 32'd0);
      chk("rst_over", 32'(game_over), 32'd0);

      // Fire in IDLE is ignored
      fire = 1'b1; tick(); fire = 1'b0; tick(); fire = 1'b1; tick(); fire = 1'b0; tick();
      chk("idle_fire_ignored", 32'(rv_cnt), 32'd0);

      target_x = 5'd5; target_y = 5'd1; player_x = 5'd5; player_y = 5'd1;
      start = 1'b1; tick(); start = 1'b0; tick();
      judge("hit_exact", 1'b1, 1, 0);

      player_x = 5'd6;
`ifdef HIT_JUDGE_TOLERANCE_EN
      judge("x_plus1", 1'b1, 2, 0);
`else
      judge("x_plus1", 1'b0, 1, 1);
`endif

      // Reset mid-TRACK
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst_track_rv", 32'(result_valid), 32'd0);
      chk("rst_track_score", 32'(score), 32'd0);
      chk("rst_track_misses", 32'(misses), 32'd0);
      chk("rst_track_hit", 32'(hit), 32'd0);
      fire = 1'b1; tick(); fire = 1'b0; tick();
      chk("rst_track_idle", 32'(rv_cnt), 32'd2);

      start = 1'b1; tick(); start = 1'b0; tick();
      player_x = 5'd7;
      judge("x_plus2_miss", 1'b0, 0, 1);
      player_x = 5'd5;
      judge("hit_a", 1'b1, 1, 1);
      judge("hit_b", 1'b1, 2, 1);
      judge("hit_c", 1'b1, 3, 1);
      judge("score_sat", 1'b1, 3, 1);

      // Timeout: RESULT exactly 16 cycles after TRACK entry, then OVER
      base = rv_cnt;
      tick(15);
      chk("no_early_timeout", 32'(rv_cnt), 32'(base));
      tick();
      chk("timeout_rv", 32'(result_valid), 32'd1);
      chk("timeout_hit", 32'(hit), 32'd0);
      tick();
      chk("over_flag", 32'(game_over), 32'd1);
      chk("over_misses", 32'(misses), 32'd2);
      chk("over_score", 32'(score), 32'd3);
      fire = 1'b1; tick(); fire = 1'b0; tick(2);
      chk("over_fire_ignored", 32'(rv_cnt), 32'(base + 1));
      chk("over_hold", 32'(game_over), 32'd1);

      start = 1'b1; tick(); start = 1'b0;
      chk("restart_score", 32'(score), 32'd0);
      chk("restart_misses", 32'(misses), 32'd0);
      chk("restart_over", 32'(game_over), 32'd0);
      tick();

      // Fire edge on the last TRACK cycle wins over timeout
      base = rv_cnt;
      tick(15);
      chk("late_no_timeout", 32'(rv_cnt), 32'(base));
      fire = 1'b1; tick();
      chk("late_fire_rv", 32'(result_valid), 32'd1);
      chk("late_fire_hit", 32'(hit), 32'd1);
      fire = 1'b0; tick();
      chk("late_fire_score", 32'(score), 32'd1);
      chk("late_fire_misses", 32'(misses), 32'd0);
      tick();

      // Fire held 50 cycles: one hit, then two timeouts end the game
      base = rv_cnt;
      fire = 1'b1; tick(50); fire = 1'b0;
      chk("held_rv_count", 32'(rv_cnt), 32'(base + 3));
      chk("held_score", 32'(score), 32'd2);
      chk("held_misses", 32'(misses), 32'd2);
      chk("held_over", 32'(game_over), 32'd1);

      // Reset during RESULT aborts the update
      tick();
      start = 1'b1; tick(); start = 1'b0; tick();
      fire = 1'b1; tick();
      chk("pre_rst_rv", 32'(result_valid), 32'd1);
      base = rv_cnt;
      reset = 1'b1; fire = 1'b0; tick(); reset = 1'b0;
      chk("rst_result_rv", 32'(result_valid), 32'd0);
      chk("rst_result_hit", 32'(hit), 32'd0);
      chk("rst_result_score", 32'(score), 32'd0);
      chk("rst_result_misses", 32'(misses), 32'd0);
      chk("rst_result_over", 32'(game_over), 32'd0);
      fire = 1'b1; tick(); fire = 1'b0; tick(2);
      chk("rst_result_idle", 32'(rv_cnt), 32'(base + 1));
      chk("rv_spacing", 32'(b2b), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
